alu_mp_seq: RTL and testbench
=============================

// Module: alu_mp_seq
// PURPOSE
//  Multi-precision arithmetic sequencer for the 16-bit ALU.
//  Accepts one WORDS*16-bit add or subtract request.
//  Issues one ALU op per cycle, least-significant word first, and chains carry through the ALU CI input.
//  Collects the result words and presents the full result with final carry/overflow on a valid/ready output.
// PARAMETERS
//  WORDS  4  number of 16-bit words per operand (>=1); counter width = clog2(WORDS)+1
// PORTS
//  clk         in   1         single clock, rising edge
//  rst_n       in   1         asynchronous, active-low reset
//  req_valid   in   1         request present
//  req_ready   out  1         sequencer can accept request
//  req_sub     in   1         0 = A+B, 1 = A-B
//  req_a       in   WORDS*16  operand A, word 0 = bits [15:0]
//  req_b       in   WORDS*16  operand B
//  alu_a       out  16        to ALU A
//  alu_b       out  16        to ALU B
//  alu_op      out  6         to ALU Op (`ALU_ADD/`ALU_ADDC/`ALU_SUB/`ALU_SUBC from constants.v)
//  alu_ci      out  1         to ALU CI
//  alu_result  in   16        from ALU Result (combinational)
//  alu_flags   in   16        from ALU Flags: [0]=CO, [1]=V
//  res_valid   out  1         result present
//  res_ready   in   1         consumer takes result
//  res_data    out  WORDS*16  result
//  res_carry   out  1         CO of last word (add: carry out; sub: 1 = no borrow)
//  res_ovf     out  1         V of last word (signed overflow of full-width op)
// BEHAVIOUR
//  Reset (async, rst_n=0) values:
//   - state=IDLE, req_ready=1, res_valid=0
//   - res_data/res_carry/res_ovf=0
//   - alu_a/alu_b/alu_ci=0, alu_op=`ALU_ADD
//  FSM states:
//   - IDLE: req_ready=1. On req_valid&&req_ready: latch A, B, sub; idx=0; go to EXEC.
//   - EXEC: req_ready=0. Drive alu_a=A[idx], alu_b=B[idx].
//     - idx==0: alu_op=ADD or SUB, alu_ci=0.
//     - idx>0: alu_op=ADDC or SUBC, alu_ci=carry reg.
//     - Each edge: store alu_result in res word idx; carry reg<=alu_flags[0]; idx++.
//     - At idx==WORDS-1: also capture res_carry and res_ovf from alu_flags, then go to DONE.
//   - DONE: res_valid=1; req_ready=0. On res_ready: res_valid<=0, go to IDLE.
//  Timing and handshake:
//   - Latency: request accepted at edge T; word i issued in cycle T+1+i; res_valid rises at edge T+WORDS.
//   - Throughput: one request per WORDS+2 cycles minimum (no accept in DONE).
//   - Outputs are registered and stable while res_valid=1 && !res_ready.
//   - req_valid while busy is ignored (req_ready=0); the requester holds its request.
//   - When not in EXEC, ALU drive lines hold their last values; consumers must ignore them.
//  Boundary conditions:
//   - WORDS=1: single EXEC cycle using ADD/SUB; res_carry/res_ovf come from that word.
//   - Reset mid-EXEC or in DONE: abort immediately, return to IDLE; the partial result is discarded (res_valid=0).
//   - idx never wraps: EXEC exits exactly at WORDS-1.
// CONFIGURATION
//  ALU_MP_SEQ_ZERO_EN defined: adds output port res_zero (1 bit).
//   - res_zero=1 iff every result word is 0.
//   - Built as a running AND updated in EXEC and registered with res_data.
//   - Reset value 0.
//  Macro not defined: no res_zero port and no zero logic; all other behaviour identical.
// TESTING (WORDS=4, real ALU attached)
//  1 add 0x0000_0000_0000_FFFF + 1 -> res_data=0x0000_0000_0001_0000, carry=0, ovf=0, res_valid at T+4
//  2 add 0xFFFF_FFFF_FFFF_FFFF + 1 -> res_data=0, carry=1, ovf=0, res_zero=1 (macro defined)
//  3 sub 0x0001_0000_0000_0000 - 1 -> res_data=0x0000_FFFF_FFFF_FFFF, carry=1 (no borrow), ovf=0
//  4 add 0x7FFF_FFFF_FFFF_FFFF + 1 -> res_data=0x8000_0000_0000_0000, ovf=1, carry=0
//  5 res_ready low 5 cycles after res_valid -> res_data stable, req_ready=0, second req_valid not accepted
//  6 rst_n low at EXEC idx=2 -> next cycle state IDLE, res_valid=0, req_ready=1; new request then completes correctly

Source files
------------

// File: rtl/alu_mp_seq.sv
// ============================================================================
// alu_mp_seq -- multi-precision add/subtract sequencer for a 16-bit ALU
//
// Purpose:
//   Accepts one WORDS*16-bit add or subtract request and streams it through
//   an external 16-bit combinational ALU one word per cycle, least
//   significant word first. The carry is chained through the ALU CI input.
//   The collected result is presented with the final carry and signed
//   overflow on a valid/ready output.
//
// Optional feature:
//   ALU_MP_SEQ_ZERO_EN -- when defined, adds output res_zero (1 = every
//   result word is zero). When undefined, the port and its logic are absent.
//
// Ports:
//   clk         in   1         clock, rising edge
//   rst_n       in   1         asynchronous active-low reset
//   req_valid   in   1         request present
//   req_ready   out  1         sequencer can accept a request
//   req_sub     in   1         0 = A+B, 1 = A-B
//   req_a       in   WORDS*16  operand A (word 0 = bits [15:0])
//   req_b       in   WORDS*16  operand B
//   alu_a       out  16        ALU operand A
//   alu_b       out  16        ALU operand B
//   alu_op      out  6         ALU opcode (ADD/ADDC/SUB/SUBC)
//   alu_ci      out  1         ALU carry in
//   alu_result  in   16        ALU result (combinational)
//   alu_flags   in   16        ALU flags, [0]=CO, [1]=V
//   res_valid   out  1         result present
//   res_ready   in   1         consumer takes the result
//   res_data    out  WORDS*16  result
//   res_carry   out  1         CO of last word (sub: 1 = no borrow)
//   res_ovf     out  1         V of last word (signed overflow of full op)
//   res_zero    out  1         (ALU_MP_SEQ_ZERO_EN only) result is zero
// ============================================================================

`ifndef ALU_ADD
`define ALU_ADD  6'h00
`endif
`ifndef ALU_ADDC
`define ALU_ADDC 6'h01
`endif
`ifndef ALU_SUB
`define ALU_SUB  6'h02
`endif
`ifndef ALU_SUBC
`define ALU_SUBC 6'h03
`endif

module alu_mp_seq #(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_sub,
    input  logic [WORDS*16-1:0]   req_a,
    input  logic [WORDS*16-1:0]   req_b,
    output logic [15:0]           alu_a,
    output logic [15:0]           alu_b,
    output logic [5:0]            alu_op,
    output logic                  alu_ci,
    input  logic [15:0]           alu_result,
    input  logic [15:0]           alu_flags,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [WORDS*16-1:0]   res_data,
    output logic                  res_carry,
`ifdef ALU_MP_SEQ_ZERO_EN
    output logic                  res_zero,
`endif
    output logic                  res_ovf
);

    localparam int DW    = WORDS * 16;
    localparam int IDX_W = $clog2(WORDS) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic               sub_q;

    // Operand words not yet issued; the word being issued sits in alu_a_q /
    // alu_b_q, so these shift down by one word per EXEC cycle.
    logic [DW-1:0]      a_rest_q;
    logic [DW-1:0]      b_rest_q;

    logic [15:0]        alu_a_q;
    logic [15:0]        alu_b_q;
    logic [5:0]         alu_op_q;
    // alu_ci_q doubles as the inter-word carry register: it is loaded with
    // the CO of word idx on the same edge that word idx+1 is presented.
    logic               alu_ci_q;

    logic               req_ready_q;
    logic               res_valid_q;
    logic [DW-1:0]      res_data_q;
    logic               res_carry_q;
    logic               res_ovf_q;
`ifdef ALU_MP_SEQ_ZERO_EN
    logic               res_zero_q;
`endif

    // Only CO and V are used from the ALU flag word.
    logic unused_flags;
    assign unused_flags = ^alu_flags[15:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            sub_q       <= 1'b0;
            a_rest_q    <= '0;
            b_rest_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= `ALU_ADD;
            alu_ci_q    <= 1'b0;
            req_ready_q <= 1'b1;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_carry_q <= 1'b0;
            res_ovf_q   <= 1'b0;
`ifdef ALU_MP_SEQ_ZERO_EN
            res_zero_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        // Present word 0 right away so the ALU result is
                        // ready to capture at the first EXEC edge.
                        alu_a_q     <= req_a[15:0];
                        alu_b_q     <= req_b[15:0];
                        a_rest_q    <= req_a >> 16;
                        b_rest_q    <= req_b >> 16;
                        alu_op_q    <= req_sub ? `ALU_SUB : `ALU_ADD;
                        alu_ci_q    <= 1'b0;
                        sub_q       <= req_sub;
                        idx_q       <= '0;
                        req_ready_q <= 1'b0;
                        state_q     <= EXEC;
                    end
                end

                EXEC: begin
                    // Result words shift in from the top; after WORDS
                    // captures word 0 lands in bits [15:0].
                    res_data_q <= DW'({alu_result, res_data_q} >> 16);
`ifdef ALU_MP_SEQ_ZERO_EN
                    res_zero_q <= ((idx_q == '0) ? 1'b1 : res_zero_q)
                                  & (alu_result == 16'h0000);
`endif
                    if (idx_q == LAST_IDX) begin
                        // ALU drive lines are left untouched here so they
                        // hold the last issued word outside EXEC.
                        res_carry_q <= alu_flags[0];
                        res_ovf_q   <= alu_flags[1];
                        res_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        idx_q    <= idx_q + IDX_W'(1);
                        alu_a_q  <= a_rest_q[15:0];
                        alu_b_q  <= b_rest_q[15:0];
                        a_rest_q <= a_rest_q >> 16;
                        b_rest_q <= b_rest_q >> 16;
                        alu_op_q <= sub_q ? `ALU_SUBC : `ALU_ADDC;
                        alu_ci_q <= alu_flags[0];
                    end
                end

                DONE: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end

                default: begin
                    res_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign alu_ci    = alu_ci_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_carry = res_carry_q;
    assign res_ovf   = res_ovf_q;
`ifdef ALU_MP_SEQ_ZERO_EN
    assign res_zero  = res_zero_q;
`endif

endmodule

// File: tb/tb_alu_mp_seq.sv
// ============================================================================
// tb_alu_mp_seq -- self-checking bench for alu_mp_seq (WORDS=4) with a
// behavioural 16-bit ALU attached. Expected results are queued when a
// request is accepted and popped when the sequencer presents its result.
// ============================================================================

`ifndef ALU_ADD
`define ALU_ADD  6'h00
`endif
`ifndef ALU_ADDC
`define ALU_ADDC 6'h01
`endif
`ifndef ALU_SUB
`define ALU_SUB  6'h02
`endif
`ifndef ALU_SUBC
`define ALU_SUBC 6'h03
`endif

module tb_alu_mp_seq;

    localparam int WORDS = 4;
    localparam int DW    = WORDS * 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_sub;
    logic [DW-1:0] req_a;
    logic [DW-1:0] req_b;
    logic [15:0]   alu_a;
    logic [15:0]   alu_b;
    logic [5:0]    alu_op;
    logic          alu_ci;
    logic [15:0]   alu_result;
    logic [15:0]   alu_flags;
    logic          res_valid;
    logic          res_ready;
    logic [DW-1:0] res_data;
    logic          res_carry;
    logic          res_ovf;
`ifdef ALU_MP_SEQ_ZERO_EN
    logic          res_zero;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] data;
        logic        carry;
        logic        ovf;
        logic        zero;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    alu_mp_seq #(.WORDS(WORDS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_sub    (req_sub),
        .req_a      (req_a),
        .req_b      (req_b),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_ci     (alu_ci),
        .alu_result (alu_result),
        .alu_flags  (alu_flags),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_carry  (res_carry),
`ifdef ALU_MP_SEQ_ZERO_EN
        .res_zero   (res_zero),
`endif
        .res_ovf    (res_ovf)
    );

    // Behavioural 16-bit ALU: SUB forces carry-in 1, ADD forces 0,
    // ADDC/SUBC use CI. CO=1 on subtract means no borrow.
    always_comb begin
        logic [15:0] bb;
        logic        cin;
        logic [16:0] s;
        bb  = (alu_op == `ALU_SUB || alu_op == `ALU_SUBC) ? ~alu_b : alu_b;
        cin = (alu_op == `ALU_SUB) ? 1'b1 :
              (alu_op == `ALU_ADD) ? 1'b0 : alu_ci;
        s   = {1'b0, alu_a} + {1'b0, bb} + {16'h0000, cin};
        alu_result   = s[15:0];
        alu_flags    = 16'h0000;
        alu_flags[0] = s[16];
        alu_flags[1] = (alu_a[15] == bb[15]) && (s[15] != alu_a[15]);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic sub);
        exp_t        e;
        logic [63:0] bb;
        logic [64:0] s;
        bb      = sub ? ~b : b;
        s       = {1'b0, a} + {1'b0, bb} + {64'd0, sub};
        e.data  = s[63:0];
        e.carry = s[64];
        e.ovf   = (a[63] == bb[63]) && (s[63] != a[63]);
        e.zero  = (s[63:0] == 64'd0);
        return e;
    endfunction

    // Drive a request, wait (bounded) for acceptance, queue its expectation
    // and check the first two issued opcodes.
    task automatic start_req(input logic [63:0] a, input logic [63:0] b,
                             input logic sub, input exp_t e);
        int cyc;
        req_a     = a;
        req_b     = b;
        req_sub   = sub;
        req_valid = 1'b1;
        cyc = 0;
        while (!req_ready && cyc < 50) begin
            tick();
            cyc++;
        end
        if (!req_ready) chk("accept_timeout", 64'(req_ready), 64'd1);
        tick();                         // acceptance edge T
        req_valid = 1'b0;
        exp_q.push_back(e);
        chk("busy_ready", 64'(req_ready), 64'd0);
        chk("op_word0", 64'(alu_op), sub ? 64'(`ALU_SUB) : 64'(`ALU_ADD));
        chk("ci_word0", 64'(alu_ci), 64'd0);
        chk("a_word0",  64'(alu_a), 64'(a[15:0]));
    endtask

    // Wait for res_valid, check latency and result against the queue head.
    task automatic wait_result(input logic sub);
        int   n;
        exp_t e;
        n = 0;
        while (!res_valid && n < 20) begin
            tick();
            n++;
            if (n == 1)
                chk("op_word1", 64'(alu_op), sub ? 64'(`ALU_SUBC) : 64'(`ALU_ADDC));
        end
        chk("latency", 64'(n), 64'(WORDS));
        if (exp_q.size() == 0) begin
            chk("queue_empty", 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            chk("res_data",  res_data, e.data);
            chk("res_carry", 64'(res_carry), 64'(e.carry));
            chk("res_ovf",   64'(res_ovf), 64'(e.ovf));
`ifdef ALU_MP_SEQ_ZERO_EN
            chk("res_zero",  64'(res_zero), 64'(e.zero));
`endif
            $display("txn sub=%0b data=%h carry=%0b ovf=%0b latency=%0d",
                     sub, res_data, res_carry, res_ovf, n);
        end
    endtask

    task automatic release_result();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("valid_drop", 64'(res_valid), 64'd0);
        chk("ready_back", 64'(req_ready), 64'd1);
    endtask

    task automatic run(input logic [63:0] a, input logic [63:0] b,
                       input logic sub, input exp_t e);
        start_req(a, b, sub, e);
        wait_result(sub);
        release_result();
    endtask

    function automatic exp_t mk(input logic [63:0] d, input logic c, input logic v);
        exp_t e;
        e.data  = d;
        e.carry = c;
        e.ovf   = v;
        e.zero  = (d == 64'd0);
        return e;
    endfunction

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;
        logic        rs;
        logic [63:0] held;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_sub   = 1'b0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_res_data",  res_data, 64'd0);
        chk("rst_carry_ovf", 64'({res_carry, res_ovf}), 64'd0);
        chk("rst_alu_op",    64'(alu_op), 64'(`ALU_ADD));
        chk("rst_alu_drive", 64'({alu_a, alu_b, alu_ci}), 64'd0);
`ifdef ALU_MP_SEQ_ZERO_EN
        chk("rst_res_zero",  64'(res_zero), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Directed vectors
        run(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, mk(64'h0000_0000_0001_0000, 1'b0, 1'b0));
        run(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, mk(64'h0000_0000_0000_0000, 1'b1, 1'b0));
        run(64'h0001_0000_0000_0000, 64'd1, 1'b1, mk(64'h0000_FFFF_FFFF_FFFF, 1'b1, 1'b0));
        run(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, mk(64'h8000_0000_0000_0000, 1'b0, 1'b1));
        run(64'd0, 64'd1, 1'b1, mk(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0));
        run(64'h8000_0000_0000_0000, 64'd1, 1'b1, mk(64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1));

        // Back-pressure: hold res_ready low, a second request waits
        start_req(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
                  mk(64'h2222_2222_2222_2211, 1'b0, 1'b0));
        wait_result(1'b0);
        held      = res_data;
        req_a     = 64'h0000_0000_0000_0005;
        req_b     = 64'h0000_0000_0000_0007;
        req_sub   = 1'b1;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_data",  res_data, held);
            chk("hold_valid", 64'(res_valid), 64'd1);
            chk("hold_ready", 64'(req_ready), 64'd0);
        end
        chk("hold_queue", 64'(exp_q.size()), 64'd0);
        release_result();
        run(64'h0000_0000_0000_0005, 64'h0000_0000_0000_0007, 1'b1,
            mk(64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0));

        // Reset in EXEC at idx=2: partial result discarded
        start_req(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 1'b0,
                  mk(64'h3333_3333_3333_3333, 1'b0, 1'b0));
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        void'(exp_q.pop_back());
        chk("abort_valid", 64'(res_valid), 64'd0);
        chk("abort_ready", 64'(req_ready), 64'd1);
        tick();
        chk("abort_idle_ready", 64'(req_ready), 64'd1);
        chk("abort_idle_valid", 64'(res_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0,
            mk(64'h0001_0000_0001_0000, 1'b0, 1'b0));

        // Random traffic scored against a 64-bit reference
        for (int i = 0; i < 4; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rs = 1'($urandom_range(0, 1));
            run(ra, rb, rs, model(ra, rb, rs));
        end

        chk("final_queue", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
